lzd_iter_ctrl: RTL and testbench



---
 rtl/lzd_iter_ctrl.sv | 125 ++++++++++++
 tb/tb_lzd_iter_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/lzd_iter_ctrl.sv
// Multi-cycle leading-zero counter: scans DATA_W operand one CHUNK_W slice per cycle from the MSB.
// Latency: result valid k+1 edges after accept (k = first non-zero slice), NCH edges for an all-zero operand.
// Backpressure: single operation in flight; ready_o only in IDLE, result held in DONE until ready_i.
// Ports: clk_i/rst_i (async active-high), flush_i (sync abort), valid_i/ready_o/data_i (operand in),
//        valid_o/ready_i/count_o/zero_o (result out; count_o/zero_o qualified by valid_o).
module lzd_iter_ctrl #(
   parameter  int DATA_W  = 64,
   parameter  int CHUNK_W = 8,
   localparam int NCH     = DATA_W / CHUNK_W,
   localparam int CNT_W   = $clog2(DATA_W + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CNT_W-1:0]  count_o,
   output logic              zero_o
);

   localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);
   localparam logic [CNT_W-1:0] CHUNK_CNT = CNT_W'(CHUNK_W);
   localparam logic [CNT_W-1:0] DATA_CNT  = CNT_W'(DATA_W);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               zero_q, zero_d;

   logic [CHUNK_W-1:0] slice;
   logic [CNT_W-1:0]   slice_lz;
   logic               slice_hit;

   // Priority encoder over the top slice; slice_lz is only consumed when the slice is non-zero.
   always_comb begin
      slice     = shreg_q[DATA_W-1 -: CHUNK_W];
      slice_lz  = '0;
      slice_hit = 1'b0;
      for (int i = CHUNK_W - 1; i >= 0; i--) begin
         if (!slice_hit) begin
            if (slice[i]) begin
               slice_hit = 1'b1;
            end else begin
               slice_lz = slice_lz + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = idx_q;
      count_d = count_q;
      zero_d  = zero_q;

      // Flush returns to IDLE but deliberately leaves count/zero untouched.
      if (flush_i) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  shreg_d = data_i;
                  count_d = '0;
                  idx_d   = '0;
                  state_d = SCAN;
               end
            end
            SCAN: begin
               if (slice == '0) begin
                  if (idx_q == LAST_IDX) begin
                     count_d = DATA_CNT;
                     zero_d  = 1'b1;
                     state_d = DONE;
                  end else begin
                     count_d = count_q + CHUNK_CNT;
                     shreg_d = shreg_q << CHUNK_W;
                     idx_d   = idx_q + IDX_W'(1);
                  end
               end else begin
                  count_d = count_q + slice_lz;
                  zero_d  = 1'b0;
                  state_d = DONE;
               end
            end
            DONE: begin
               if (ready_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q   <= '0;
         count_q <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         zero_q  <= zero_d;
      end
   end

   assign ready_o = (state_q == IDLE);
   assign valid_o = (state_q == DONE);
   assign count_o = count_q;
   assign zero_o  = zero_q;

endmodule

// File: tb/tb_lzd_iter_ctrl.sv
module tb_lzd_iter_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [63:0] data_i = '0;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic [6:0]  count_o;
   logic        zero_o;

   int total = 0;
   int bad   = 0;

   lzd_iter_ctrl dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .count_o (count_o),
      .zero_o  (zero_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: bit-by-bit leading-zero count and the latency rule from slice position.
   function automatic int lz_ref(input logic [63:0] d);
      for (int i = 63; i >= 0; i--) begin
         if (d[i]) return 63 - i;
      end
      return 64;
   endfunction

   function automatic int lat_ref(input int c);
      return (c == 64) ? 8 : (c / 8) + 1;
   endfunction

   // Transaction-level model: idle / busy-for-N-edges / holding result.
   logic m_valid, m_ready, m_pend, m_zero;
   int   m_left, m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0; m_ready <= 1'b1; m_pend <= 1'b0;
         m_left  <= 0;    m_cnt   <= 0;    m_zero <= 1'b0;
      end else if (flush_i) begin
         m_valid <= 1'b0; m_ready <= 1'b1; m_pend <= 1'b0;
      end else if (m_ready && valid_i) begin
         m_ready <= 1'b0;
         m_pend  <= 1'b1;
         m_left  <= lat_ref(lz_ref(data_i));
         m_cnt   <= lz_ref(data_i);
         m_zero  <= (data_i == 64'd0);
      end else if (m_pend) begin
         if (m_left == 1) begin
            m_pend  <= 1'b0;
            m_valid <= 1'b1;
         end else begin
            m_left <= m_left - 1;
         end
      end else if (m_valid && ready_i) begin
         m_valid <= 1'b0;
         m_ready <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_valid_o", int'(valid_o), int'(m_valid));
         chk("cyc_ready_o", int'(ready_o), int'(m_ready));
         if (m_valid) begin
            chk("cyc_count_o", int'(count_o), m_cnt);
            chk("cyc_zero_o",  int'(zero_o),  int'(m_zero));
         end
      end
   end

   // Called at posedge+1 with DUT idle. Checks latency, result, then holds
   // the result for 'hold' cycles (optionally pulsing valid_i) before draining.
   task automatic do_op(input string name, input logic [63:0] d, input int exp_cnt,
                        input int exp_lat, input bit exp_z, input int hold, input bit pulse);
      logic [6:0] cnt_seen;
      int edges;
      chk({name, "_idle"}, int'(ready_o), 1);
      chk({name, "_ref"}, lz_ref(d), exp_cnt);
      valid_i = 1'b1;
      data_i  = d;
      @(posedge clk); #1;
      valid_i = 1'b0;
      data_i  = {$urandom, $urandom};
      edges = 0;
      do begin
         @(posedge clk); #1;
         edges++;
      end while (!valid_o && edges < 100);
      chk({name, "_lat"},   edges, exp_lat);
      chk({name, "_count"}, int'(count_o), exp_cnt);
      chk({name, "_zero"},  int'(zero_o), int'(exp_z));
      cnt_seen = count_o;
      for (int h = 0; h < hold; h++) begin
         valid_i = pulse ? 1'b1 : 1'b0;
         data_i  = {$urandom, $urandom};
         @(posedge clk); #1;
         if (pulse) begin
            chk({name, "_bp_valid"}, int'(valid_o), 1);
            chk({name, "_bp_ready"}, int'(ready_o), 0);
            chk({name, "_bp_count"}, int'(count_o), int'(cnt_seen));
         end
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
      @(posedge clk); #1;
      ready_i = 1'b0;
      chk({name, "_drain_ready"}, int'(ready_o), 1);
      chk({name, "_drain_valid"}, int'(valid_o), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int c;
      // Inputs asserted during reset must be ignored.
      valid_i = 1'b1; ready_i = 1'b1; data_i = 64'h8000_0000_0000_0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready_o", int'(ready_o), 1);
      chk("rst_valid_o", int'(valid_o), 0);
      chk("rst_count_o", int'(count_o), 0);
      chk("rst_zero_o",  int'(zero_o),  0);
      valid_i = 1'b0; ready_i = 1'b0;
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      do_op("top8000", 64'h8000_0000_0000_0000, 0,  1, 1'b0, 0, 1'b0);
      do_op("top1000", 64'h1000_0000_0000_0000, 3,  1, 1'b0, 1, 1'b0);
      do_op("s1_0080", 64'h0080_0000_0000_0000, 8,  2, 1'b0, 0, 1'b0);
      do_op("lsb_one", 64'h0000_0000_0000_0001, 63, 8, 1'b0, 0, 1'b0);
      do_op("allzero", 64'h0,                   64, 8, 1'b1, 0, 1'b0);
      do_op("ff_next", 64'hFF00_0000_0000_0000, 0,  1, 1'b0, 0, 1'b0);
      do_op("backpr",  64'h0000_0400_0000_0000, 21, 3, 1'b0, 5, 1'b1);

      // Asynchronous reset in the middle of a scan.
      valid_i = 1'b1; data_i = 64'h0000_0000_0000_0001;
      @(posedge clk); #1;
      valid_i = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid_o", int'(valid_o), 0);
      chk("arst_ready_o", int'(ready_o), 1);
      chk("arst_count_o", int'(count_o), 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      do_op("post_rst_0100", 64'h0100_0000_0000_0000, 7,  1, 1'b0, 0, 1'b0);
      do_op("post_rst_0001", 64'h0001_0000_0000_0000, 15, 2, 1'b0, 0, 1'b0);

      // Flush during the second scan cycle, with a competing valid_i.
      valid_i = 1'b1; data_i = 64'h0000_0000_0000_0100;
      @(posedge clk); #1;
      valid_i = 1'b0;
      @(posedge clk); #1;
      flush_i = 1'b1; valid_i = 1'b1; data_i = 64'h8000_0000_0000_0000;
      @(posedge clk); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      chk("flush_ready_o", int'(ready_o), 1);
      chk("flush_valid_o", int'(valid_o), 0);
      repeat (8) begin
         @(posedge clk); #1;
         chk("flush_no_result", int'(valid_o), 0);
      end
      do_op("post_flush", 64'h0000_0000_0000_0100, 55, 7, 1'b0, 0, 1'b0);

      // Randomised operands with varied leading-zero depth and hold time.
      for (int n = 0; n < 150; n++) begin
         d = {$urandom, $urandom};
         d = d >> $urandom_range(0, 64);
         c = lz_ref(d);
         do_op("rand", d, c, lat_ref(c), (d == 64'd0), $urandom_range(0, 3), 1'(($urandom % 2)));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
